median_feeder: RTL and testbench
================================

# median_feeder

Initiator side of the median filter's serial pixel interface. It accepts a 3x3 window as nine pixels on a valid/ready stream and buffers them, then bursts them into the median core on DI/DSI. It waits for the core's DSO, captures the result on a valid/ready output and resets the core before the next window. It sits between the window-extraction logic and the median core.

## Interface
- width, 8, pixel and result bit width
- TIMEOUT_CYC, 64, maximum WAIT cycles before the window is dropped (>= 2)

- CLK  in  1  clock, all logic on rising edge
- nRST  in  1  reset, synchronous, active-low
- PI  in  width  incoming pixel
- PVALID  in  1  PI valid
- PREADY  out  1  feeder can accept PI
- MDI  out  width  pixel to median core DI
- MDSI  out  1  strobe to median core DSI
- MRST_N  out  1  reset to median core nRST
- MDO  in  width  median core DO
- MDSO  in  1  median core DSO (result valid, sticky until core reset)
- RO  out  width  captured median
- RVALID  out  1  RO valid
- RREADY  in  1  downstream accepts RO
- TIMEOUT  out  1  sticky error: core failed to answer

## Operation
- State machine has five states:
  - CLR: MRST_N=0 for exactly 1 cycle, then go to LOAD. CLR is the reset state.
  - LOAD: PREADY=1. Each cycle with PVALID&&PREADY writes PI into buf[cnt] and increments cnt. On the 9th accept (cnt==8), clear cnt and go to SEND.
  - SEND: MDSI=1 and MDI=buf[cnt] for cnt=0..8, in arrival order, for exactly 9 consecutive cycles. After cnt==8, clear cnt and go to WAIT.
  - WAIT: MDSI=0 and wcnt increments each cycle.
    - MDSO==1: RO<=MDO, go to OUT.
    - wcnt==TIMEOUT_CYC-1 with no MDSO: TIMEOUT<=1, go to CLR. The window is dropped and no RVALID is produced.
  - OUT: RVALID=1 with RO held stable. On RREADY==1, go to CLR.
- Control outputs are decoded from the state register only (Moore):
  - PREADY, MDSI, MRST_N and RVALID.
  - MDI=0 outside SEND.
- MRST_N=1 in every state except CLR.
- MDSO is ignored outside WAIT.
- The 9-entry buffer is width bits per entry.
- cnt is 4 bits.
- wcnt is $clog2(TIMEOUT_CYC) bits and is cleared on entry to WAIT.
- TIMEOUT is cleared only by nRST.
- One window is in flight at a time: no pixel is accepted outside LOAD.
- RO is held from capture until the next capture.

## Timing
- Reset (nRST==0 at a rising edge) takes effect at that edge and applies in any state, including mid-SEND or mid-WAIT.
  - Next-state values: state=CLR, cnt=0, wcnt=0.
  - Output values: PREADY=0, MDSI=0, MDI=0, MRST_N=0, RVALID=0, RO=0, TIMEOUT=0.
- After nRST is released, the first cycle is CLR (MRST_N=0). PREADY=1 from the following cycle.
- Back-to-back pixels with PVALID held high take 9 cycles in LOAD. MDSI rises on the cycle after the 9th accept.
- MDSI is high for exactly 9 cycles, never fewer and never split.
- Result capture: if MDSO is sampled high in WAIT cycle k, RVALID=1 from cycle k+1.
- OUT→CLR: if RREADY is sampled high with RVALID, RVALID=0 and MRST_N=0 on the next cycle. PREADY=1 one cycle after that.
- Minimum period per window: 9 (LOAD) + 9 (SEND) + W (WAIT) + 1 (OUT) + 1 (CLR) cycles.
- Timeout: if MDSO never rises, TIMEOUT=1 and MRST_N=0 on the cycle after the TIMEOUT_CYC-th WAIT cycle.
- MDSO rising on the same cycle wcnt reaches TIMEOUT_CYC-1: the result wins (capture, no TIMEOUT).

## Test plan
- **Basic window:** reset; feed 1..9 back-to-back; behavioural core raises MDSO=1 with MDO=5 after 36 WAIT cycles; RREADY=1.
  - MRST_N low 1 cycle after reset.
  - MDSI high exactly 9 cycles with MDI=1,2,...,9.
  - RVALID=1 with RO=5 one cycle after MDSO.
  - MRST_N low 1 cycle after the handshake.
- **Gapped input:** feed 9 pixels with PVALID toggling 1/0.
  - Buffered order is preserved.
  - MDSI rises only after the 9th accept.
  - PREADY=1 throughout LOAD.
- **Backpressure:** RREADY=0 for 10 cycles in OUT.
  - RVALID and RO stable.
  - PREADY=0 and MDSI=0.
  - Exactly one MRST_N low cycle after RREADY=1.
- **Timeout:** core never asserts MDSO.
  - TIMEOUT=1 after 64 WAIT cycles.
  - No RVALID.
  - Returns to LOAD via CLR.
  - The next window with a responsive core completes with TIMEOUT still 1.
- **Reset mid-SEND:** nRST=0 on SEND cycle 4.
  - All outputs take reset values next edge; MDSI=0.
  - A following window 9..1 is sent complete and in order.
- **Integration with the real median core:** window {200,3,77,12,255,0,90,45,128}, then a second window {10,10,10,10,10,10,10,10,10}.
  - RO=77, then RO=10.
  - The core is reset between windows (MRST_N pulse).

Source files
------------

// File: rtl/median_feeder.sv
// median_feeder
//   Initiator side of the median core's serial pixel interface. It collects
//   one 3x3 window (nine pixels) from an upstream valid/ready stream and
//   bursts it into the median core on MDI/MDSI. It then waits for the core's
//   result strobe, presents the result on a valid/ready output, and pulses
//   the core reset before the next window. Only one window is in flight.
//
// Parameters
//   width        pixel / result width
//   TIMEOUT_CYC  WAIT cycles allowed before a window is dropped (>= 2)
//
// Ports
//   CLK            clock, rising edge
//   nRST           synchronous active-low reset
//   PI/PVALID      incoming pixel stream; PREADY high while collecting
//   MDI/MDSI       pixel and strobe to the median core
//   MRST_N         active-low reset to the median core (low in CLR only)
//   MDO/MDSO       median core result and sticky result-valid
//   RO/RVALID      captured median; RREADY from downstream
//   TIMEOUT        sticky flag: the core failed to answer a window

module median_feeder #(
    parameter int width       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [width-1:0] PI,
    input  logic             PVALID,
    output logic             PREADY,
    output logic [width-1:0] MDI,
    output logic             MDSI,
    output logic             MRST_N,
    input  logic [width-1:0] MDO,
    input  logic             MDSO,
    output logic [width-1:0] RO,
    output logic             RVALID,
    input  logic             RREADY,
    output logic             TIMEOUT
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    typedef enum logic [2:0] {
        ST_CLR,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [width-1:0]  ro_q, ro_d;
    logic              timeout_q, timeout_d;

    // Window buffer: written in arrival order, read back by cnt during SEND.
    logic [width-1:0]  buf_q [9];
    logic              accept;

    assign accept = (state_q == ST_LOAD) && PVALID;

    always_ff @(posedge CLK) begin
        if (accept) begin
            buf_q[cnt_q] <= PI;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        ro_d      = ro_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_CLR: begin
                cnt_d   = 4'd0;
                wcnt_d  = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_q == 4'd8) begin
                        cnt_d   = 4'd0;
                        state_d = ST_SEND;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_SEND: begin
                if (cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    wcnt_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q + WCNT_ONE;
                // A result arriving on the last allowed cycle still wins.
                if (MDSO) begin
                    ro_d    = MDO;
                    state_d = ST_OUT;
                end else if (wcnt_q == WCNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_CLR;
                end
            end
            ST_OUT: begin
                if (RREADY) begin
                    state_d = ST_CLR;
                end
            end
            default: begin
                state_d = ST_CLR;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= ST_CLR;
            cnt_q     <= 4'd0;
            wcnt_q    <= '0;
            ro_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            ro_q      <= ro_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore outputs decoded from the state register
    assign PREADY  = (state_q == ST_LOAD);
    assign MDSI    = (state_q == ST_SEND);
    assign MRST_N  = (state_q != ST_CLR);
    assign RVALID  = (state_q == ST_OUT);
    assign MDI     = (state_q == ST_SEND) ? buf_q[cnt_q] : '0;
    assign RO      = ro_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_median_feeder.sv
// tb_median_feeder
//   Self-checking bench for median_feeder. A behavioural median core answers
//   each burst after a programmable number of WAIT cycles (or never). Every
//   window's expected burst, result, latency and handshake timing come from
//   the pixel list fed in and the programmed core latency.

module tb_median_feeder;

    localparam int W  = 8;
    localparam int TO = 64;

    logic         CLK    = 1'b0;
    logic         nRST   = 1'b0;
    logic [W-1:0] PI     = '0;
    logic         PVALID = 1'b0;
    logic         PREADY;
    logic [W-1:0] MDI;
    logic         MDSI;
    logic         MRST_N;
    logic [W-1:0] MDO;
    logic         MDSO;
    logic [W-1:0] RO;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic         TIMEOUT;

    always #5 CLK = ~CLK;

    median_feeder #(
        .width      (W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .PI     (PI),
        .PVALID (PVALID),
        .PREADY (PREADY),
        .MDI    (MDI),
        .MDSI   (MDSI),
        .MRST_N (MRST_N),
        .MDO    (MDO),
        .MDSO   (MDSO),
        .RO     (RO),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .TIMEOUT(TIMEOUT)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] median9(input logic [71:0] v);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = v[8*i +: 8];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    t      = a[j];
                    a[j]   = a[j+1];
                    a[j+1] = t;
                end
            end
        end
        return a[4];
    endfunction

    // ---------------- behavioural median core ----------------
    // MDSO rises in WAIT cycle core_lat (1-based) and stays high until reset.
    int         core_lat  = 1;
    bit         core_dead = 1'b0;
    logic [71:0] core_vec = '0;
    int         core_n    = 0;
    int         core_wc   = 0;
    logic       core_armed = 1'b0;
    logic       core_dso  = 1'b0;
    logic [7:0] core_do   = '0;

    assign MDSO = core_dso;
    assign MDO  = core_do;

    always @(posedge CLK) begin : core_model
        logic [71:0] tmp;
        if (!MRST_N || !nRST) begin
            core_n     <= 0;
            core_wc    <= 0;
            core_armed <= 1'b0;
            core_dso   <= 1'b0;
            core_do    <= 8'($urandom);
        end else begin
            // Garbage on DO until the result is valid.
            if (!core_dso) core_do <= 8'($urandom);
            if (MDSI && core_n < 9) begin
                tmp = core_vec;
                tmp[8*core_n +: 8] = MDI;
                core_vec <= tmp;
                core_n   <= core_n + 1;
                if (core_n == 8) begin
                    core_armed <= 1'b1;
                    core_wc    <= 1;
                    if (core_lat == 1 && !core_dead) begin
                        core_dso <= 1'b1;
                        core_do  <= median9(tmp);
                    end
                end
            end else if (core_armed && !core_dso && !core_dead) begin
                core_wc <= core_wc + 1;
                if (core_wc + 1 == core_lat) begin
                    core_dso <= 1'b1;
                    core_do  <= median9(core_vec);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] win_pix [9];
    logic [7:0] exp_ro      = '0;
    logic       exp_timeout = 1'b0;
    int         win_no      = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_window();
        for (int i = 0; i < 9; i++) win_pix[i] = 8'($urandom);
    endtask

    // Starts in a LOAD cycle; returns in the first SEND cycle.
    task automatic feed_window(input bit gapped);
        int k;
        bit tog;
        k   = 0;
        tog = 1'b0;
        check_eq("ro_held", RO, exp_ro);
        check_eq("timeout_flag", TIMEOUT, exp_timeout);
        while (k < 9) begin
            if (gapped && tog) begin
                PVALID = 1'b0;
                PI     = 8'($urandom);
            end else begin
                PVALID = 1'b1;
                PI     = win_pix[k];
            end
            check_eq("load_pready", PREADY, 1);
            check_eq("load_mdsi", MDSI, 0);
            tick();
            if (PVALID) k++;
            tog = !tog;
        end
        PVALID = 1'b0;
        PI     = 8'($urandom);
    endtask

    task automatic run_window(input bit gapped, input int lat, input bit dead, input int bp);
        logic [71:0] v;
        logic [7:0]  med;
        int          n;
        for (int i = 0; i < 9; i++) v[8*i +: 8] = win_pix[i];
        med       = median9(v);
        core_lat  = lat;
        core_dead = dead;
        win_no++;
        feed_window(gapped);
        for (int i = 0; i < 9; i++) begin
            check_eq("send_mdsi", MDSI, 1);
            check_eq("send_mdi", MDI, win_pix[i]);
            check_eq("send_pready", PREADY, 0);
            tick();
        end
        check_eq("wait_mdsi", MDSI, 0);
        check_eq("wait_mdi", MDI, 0);
        n = 0;
        while (RVALID !== 1'b1 && MRST_N !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (dead) begin
            exp_timeout = 1'b1;
            check_eq("timeout_wait_cycles", n, TO);
            check_eq("timeout_set", TIMEOUT, 1);
            check_eq("timeout_no_rvalid", RVALID, 0);
            check_eq("timeout_mrst", MRST_N, 0);
            tick();
            check_eq("timeout_back_load", PREADY, 1);
            check_eq("timeout_mrst_high", MRST_N, 1);
            $display("window %0d: dropped after %0d WAIT cycles, TIMEOUT=%0d", win_no, n, TIMEOUT);
            return;
        end
        check_eq("wait_cycles", n, lat);
        check_eq("rvalid", RVALID, 1);
        check_eq("ro", RO, med);
        check_eq("out_timeout", TIMEOUT, exp_timeout);
        exp_ro = med;
        for (int i = 0; i < bp; i++) begin
            tick();
            check_eq("bp_rvalid", RVALID, 1);
            check_eq("bp_ro", RO, med);
            check_eq("bp_pready", PREADY, 0);
            check_eq("bp_mdsi", MDSI, 0);
            check_eq("bp_mrst", MRST_N, 1);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check_eq("hs_rvalid", RVALID, 0);
        check_eq("hs_mrst", MRST_N, 0);
        check_eq("hs_pready", PREADY, 0);
        check_eq("hs_ro", RO, med);
        tick();
        check_eq("clr_mrst", MRST_N, 1);
        check_eq("clr_pready", PREADY, 1);
        $display("window %0d: RO=%0d after %0d WAIT cycles, backpressure %0d", win_no, RO, n, bp);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_pready", PREADY, 0);
        check_eq("rst_mdsi", MDSI, 0);
        check_eq("rst_mdi", MDI, 0);
        check_eq("rst_mrst", MRST_N, 0);
        check_eq("rst_rvalid", RVALID, 0);
        check_eq("rst_ro", RO, 0);
        check_eq("rst_timeout", TIMEOUT, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and the single CLR cycle after release
        nRST = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        nRST = 1'b1;
        tick();
        check_eq("post_rst_mrst", MRST_N, 1);
        check_eq("post_rst_pready", PREADY, 1);
        $display("reset: released, CLR for one cycle");

        // Basic window 1..9, core answers in WAIT cycle 36
        for (int i = 0; i < 9; i++) win_pix[i] = 8'(i + 1);
        run_window(1'b0, 36, 1'b0, 0);
        check_eq("basic_ro", RO, 5);

        // Gapped input with 10 cycles of backpressure
        rand_window();
        run_window(1'b1, int'($urandom_range(1, 20)), 1'b0, 10);

        // Result on the last allowed WAIT cycle wins over the timeout
        rand_window();
        run_window(1'b0, TO, 1'b0, 0);
        check_eq("boundary_no_timeout", TIMEOUT, 0);

        // Fastest core
        rand_window();
        run_window(1'b0, 1, 1'b0, 1);

        // Core never answers
        rand_window();
        run_window(1'b0, 1, 1'b1, 0);

        // Next window completes with TIMEOUT still set
        rand_window();
        run_window(1'b1, 5, 1'b0, 2);
        check_eq("timeout_sticky", TIMEOUT, 1);

        // Reset in SEND cycle 4
        rand_window();
        core_dead = 1'b0;
        core_lat  = 3;
        feed_window(1'b0);
        tick();
        tick();
        tick();
        check_eq("midsend_mdsi", MDSI, 1);
        check_eq("midsend_mdi", MDI, win_pix[3]);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        check_reset_outputs();
        exp_ro      = '0;
        exp_timeout = 1'b0;
        tick();
        check_eq("midsend_post_pready", PREADY, 1);
        check_eq("midsend_post_mrst", MRST_N, 1);
        $display("reset: applied mid-SEND");

        for (int i = 0; i < 9; i++) win_pix[i] = 8'(9 - i);
        run_window(1'b0, 12, 1'b0, 2);
        check_eq("reverse_ro", RO, 5);

        // Median windows with known answers
        win_pix = '{8'd200, 8'd3, 8'd77, 8'd12, 8'd255, 8'd0, 8'd90, 8'd45, 8'd128};
        run_window(1'b0, 20, 1'b0, 0);
        check_eq("integ_ro_77", RO, 77);
        for (int i = 0; i < 9; i++) win_pix[i] = 8'd10;
        run_window(1'b0, 20, 1'b0, 0);
        check_eq("integ_ro_10", RO, 10);

        // Random windows
        for (int w = 0; w < 6; w++) begin
            rand_window();
            run_window(1'($urandom), int'($urandom_range(1, 40)), 1'b0,
                       int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
